// File: rtl/tpu_result_drain.sv
// Drains the results SRAM after a matmul: reads each row, requantizes every lane to a
// saturated signed byte and streams rows out through a 2-entry prefetch buffer.
module tpu_result_drain #(
    parameter int unsigned ADDRESSSIZE    = 10,
    parameter int unsigned MATRIX_SIZE    = 32,
    parameter int unsigned PARTIAL_SUM_BW = 24,
    parameter int unsigned OUT_BW         = 8,
    parameter int unsigned NUM_ROWS       = 32
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic                                 start,
    input  logic [4:0]                           shift,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 valid_address,
    output logic [ADDRESSSIZE-1:0]               res_address,
    input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] res_data,
    output logic                                 m_valid,
    input  logic                                 m_ready,
    output logic [OUT_BW*MATRIX_SIZE-1:0]        m_data,
    output logic                                 m_last
);

    localparam int unsigned RowW = OUT_BW * MATRIX_SIZE;
    localparam int unsigned SumW = PARTIAL_SUM_BW + 1;
    localparam logic [4:0] MaxShift = 5'(PARTIAL_SUM_BW - 1);
    localparam logic signed [SumW-1:0] SatHi = SumW'((1 << (OUT_BW - 1)) - 1);
    localparam logic signed [SumW-1:0] SatLo = ~SatHi;
    localparam logic [ADDRESSSIZE-1:0] LastAddr = ADDRESSSIZE'(NUM_ROWS - 1);

    typedef enum logic [1:0] {StIdle, StRun, StFlush} state_e;

    state_e                 state_q, state_d;
    logic [4:0]             shift_q, shift_d;
    logic [ADDRESSSIZE-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDRESSSIZE-1:0] addr_q, addr_d;
    logic                   inflight_q, inflight_d;
    logic                   infl_last_q, infl_last_d;
    logic                   done_q, done_d;
    logic [RowW-1:0]        buf_data_q [2];
    logic [1:0]             buf_last_q;
    logic                   rd_idx_q, wr_idx_q;
    logic [1:0]             occ_q, occ_d;
    logic                   issue, push, pop;
    logic [2:0]             load;
    logic [RowW-1:0]        rq_row;

    // Round half up, then arithmetic shift; the extra sum bit absorbs the rounding carry.
    function automatic logic [OUT_BW-1:0] requant(input logic [PARTIAL_SUM_BW-1:0] x,
                                                  input logic [4:0] s);
        logic [4:0]             s_eff;
        logic signed [SumW-1:0] rnd, sum, y;
        logic [OUT_BW-1:0]      res;
        s_eff = (s > MaxShift) ? MaxShift : s;
        rnd   = '0;
        if (s_eff != 5'd0) rnd[s_eff - 5'd1] = 1'b1;
        sum = $signed({x[PARTIAL_SUM_BW-1], x}) + rnd;
        y   = sum >>> s_eff;
        if (y > SatHi)      res = SatHi[OUT_BW-1:0];
        else if (y < SatLo) res = SatLo[OUT_BW-1:0];
        else                res = y[OUT_BW-1:0];
        return res;
    endfunction

    always_comb begin
        rq_row = '0;
        for (int i = 0; i < MATRIX_SIZE; i++) begin
            rq_row[i*OUT_BW +: OUT_BW] =
                requant(res_data[i*PARTIAL_SUM_BW +: PARTIAL_SUM_BW], shift_q);
        end
    end

    assign m_valid = (occ_q != 2'd0);
    assign pop     = m_valid & m_ready;
    assign push    = inflight_q;
    // Occupancy after this cycle's pop lets a new issue overlap a drain for 1 row/cycle.
    assign load    = 3'(occ_q) + 3'(inflight_q) - 3'(pop);

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        rd_ptr_d    = rd_ptr_q;
        addr_d      = addr_q;
        inflight_d  = 1'b0;
        infl_last_d = 1'b0;
        done_d      = 1'b0;
        issue       = 1'b0;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d  = StRun;
                    shift_d  = shift;
                    rd_ptr_d = '0;
                end
            end
            StRun: begin
                if (load < 3'd2) begin
                    issue      = 1'b1;
                    inflight_d = 1'b1;
                    addr_d     = rd_ptr_q;
                    rd_ptr_d   = rd_ptr_q + ADDRESSSIZE'(1);
                    if (rd_ptr_q == LastAddr) begin
                        infl_last_d = 1'b1;
                        state_d     = StFlush;
                    end
                end
            end
            StFlush: begin
                if (pop && m_last) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        occ_d = occ_q + 2'(push) - 2'(pop);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= StIdle;
            shift_q     <= '0;
            rd_ptr_q    <= '0;
            addr_q      <= '0;
            inflight_q  <= 1'b0;
            infl_last_q <= 1'b0;
            done_q      <= 1'b0;
            buf_data_q[0] <= '0;
            buf_data_q[1] <= '0;
            buf_last_q  <= '0;
            rd_idx_q    <= 1'b0;
            wr_idx_q    <= 1'b0;
            occ_q       <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            rd_ptr_q    <= rd_ptr_d;
            addr_q      <= addr_d;
            inflight_q  <= inflight_d;
            infl_last_q <= infl_last_d;
            done_q      <= done_d;
            occ_q       <= occ_d;
            if (push) begin
                buf_data_q[wr_idx_q] <= rq_row;
                buf_last_q[wr_idx_q] <= infl_last_q;
                wr_idx_q             <= ~wr_idx_q;
            end
            if (pop) rd_idx_q <= ~rd_idx_q;
        end
    end

    assign busy          = (state_q != StIdle);
    assign valid_address = busy;
    assign done          = done_q;
    assign res_address   = issue ? rd_ptr_q : addr_q;
    assign m_data        = buf_data_q[rd_idx_q];
    assign m_last        = m_valid & buf_last_q[rd_idx_q];

endmodule

// File: tb/tb_tpu_result_drain.sv
// Scoreboard bench for tpu_result_drain: expected rows are queued when an SRAM image is
// loaded and compared as rows are handshaken out.
module tb_tpu_result_drain;

    localparam int AW = 10;
    localparam int MS = 32;
    localparam int PW = 24;
    localparam int OW = 8;
    localparam int NR = 32;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             start = 1'b0;
    logic [4:0]       shift = '0;
    logic             busy, done, valid_address, m_valid, m_last;
    logic             m_ready = 1'b1;
    logic [AW-1:0]    res_address;
    logic [MS*PW-1:0] res_data = '0;
    logic [MS*OW-1:0] m_data;

    tpu_result_drain dut (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start),
        .shift        (shift),
        .busy         (busy),
        .done         (done),
        .valid_address(valid_address),
        .res_address  (res_address),
        .res_data     (res_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_last       (m_last)
    );

    always #5 clk = ~clk;

    int               n_checks = 0;
    int               n_errors = 0;
    int               cyc = 0;
    int               job_start = 0;
    int               pop_cnt = 0;
    bit               bp_mode = 1'b0;
    bit               hold_prev = 1'b0;
    logic [MS*OW-1:0] prev_data;
    logic             prev_last;
    logic [MS*PW-1:0] mem [NR];
    logic [MS*OW:0]   exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read SRAM: data for an address appears one cycle later.
    always @(posedge clk) res_data <= mem[res_address[4:0]];

    task automatic check_eq(input string tag, input logic [299:0] got,
                            input logic [299:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] model_rq(input logic [23:0] lane, input int sh);
        longint x, y;
        int     s;
        x = longint'($signed(lane));
        s = (sh > 23) ? 23 : sh;
        if (s > 0) x = x + (longint'(1) << (s - 1));
        y = x >>> s;
        if (y > 127)  y = 127;
        if (y < -128) y = -128;
        return y[7:0];
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            #1 m_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!rstn) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev)
                check_eq("hold_stable", {m_valid, m_last, m_data}, {1'b1, prev_last, prev_data});
            if (m_valid && m_ready) begin
                check_eq("row_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check_eq("row_data", {m_last, m_data}, exp_q.pop_front());
                pop_cnt++;
            end
            hold_prev = m_valid && !m_ready;
            prev_data = m_data;
            prev_last = m_last;
        end
    end

    // mode 0: lanes=r; 1..3: fixed lane tables with hand-computed results; 4: random; 5: ramp
    task automatic load_rows(input int mode, input logic [4:0] sh);
        logic [23:0]      v, tin[4];
        logic [7:0]       e, tout[4];
        logic [MS*OW-1:0] row;
        case (mode)
            1: begin
                tin  = '{24'd100, -24'sd100, 24'd24, -24'sd24};
                tout = '{8'd6, -8'sd6, 8'd2, -8'sd1};
            end
            2: begin
                tin  = '{24'd200, -24'sd200, 24'h7FFFFF, 24'h800000};
                tout = '{8'd127, -8'sd128, 8'd127, -8'sd128};
            end
            3: begin
                tin  = '{24'd200, -24'sd200, 24'h7FFFFF, 24'h800000};
                tout = '{8'd0, 8'd0, 8'd1, -8'sd1};
            end
            default: begin
                tin  = '{24'd0, 24'd0, 24'd0, 24'd0};
                tout = '{8'd0, 8'd0, 8'd0, 8'd0};
            end
        endcase
        for (int r = 0; r < NR; r++) begin
            row = '0;
            for (int i = 0; i < MS; i++) begin
                case (mode)
                    0: begin v = 24'(r); e = 8'(r); end
                    1, 2, 3: begin v = tin[i % 4]; e = tout[i % 4]; end
                    4: begin v = 24'($urandom); e = model_rq(v, int'(sh)); end
                    default: begin v = 24'(r * 37 + i * 11 - 600); e = model_rq(v, int'(sh)); end
                endcase
                mem[r][i*PW +: PW] = v;
                row[i*OW +: OW]    = e;
            end
            exp_q.push_back({r == NR - 1, row});
        end
    endtask

    task automatic start_job(input logic [4:0] sh);
        int fv;
        pop_cnt = 0;
        @(posedge clk);
        #1 start = 1'b1;
        shift = sh;
        @(posedge clk);
        #1 start = 1'b0;
        shift     = ~sh;
        job_start = cyc;
        @(negedge clk);
        check_eq("issue_addr0", {busy, valid_address, res_address, m_valid},
                 {1'b1, 1'b1, 10'd0, 1'b0});
        fv = -1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (m_valid) begin
                fv = cyc - job_start;
                break;
            end
        end
        check_eq("first_valid", fv, 2);
    endtask

    task automatic wait_done(input int exp_cyc);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("done_seen", seen, 1);
        if (seen && exp_cyc > 0) check_eq("done_cycle", cyc - job_start, exp_cyc);
        @(negedge clk);
        check_eq("done_pulse", {done, busy, m_valid}, 0);
        check_eq("rows_drained", exp_q.size(), 0);
    endtask

    initial begin
        bit seen, any;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(negedge clk);
        check_eq("reset_idle",
                 {busy, done, valid_address, res_address, m_valid, m_last, m_data}, 0);

        load_rows(0, 5'd0);  start_job(5'd0);  wait_done(34);
        load_rows(1, 5'd4);  start_job(5'd4);  wait_done(34);
        load_rows(2, 5'd0);  start_job(5'd0);  wait_done(34);
        load_rows(3, 5'd31); start_job(5'd31); wait_done(34);

        bp_mode = 1'b1;
        load_rows(4, 5'd3); start_job(5'd3); wait_done(0);
        bp_mode = 1'b0;

        // A start while busy must not relatch shift or restart the job.
        load_rows(5, 5'd2); start_job(5'd2);
        repeat (5) @(posedge clk);
        #1 start = 1'b1;
        shift = 5'd0;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(34);
        load_rows(5, 5'd1); start_job(5'd1); wait_done(34);

        // Abort mid-job with reset.
        load_rows(4, 5'd5); start_job(5'd5);
        seen = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk);
            if (pop_cnt >= 10) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq("reached_row10", seen, 1);
        #1 rstn = 1'b0;
        #1 check_eq("abort_reset",
                    {busy, done, valid_address, res_address, m_valid, m_last, m_data}, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        any = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            any = any | done | m_valid | busy;
        end
        check_eq("abort_quiet", any, 0);
        load_rows(0, 5'd0); start_job(5'd0); wait_done(34);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
